s2p_rx: RTL and testbench
=========================

# s2p_rx

Serial-to-parallel receiver for the inter-board battle link. Consumes the 10-bit frames produced by the transmit-side parallel-to-serial shift register: start bit 0, eight data bits MSB first, stop bit 1, line idle high. Runs entirely on CLOCK_50 with an internal bit-period counter. Hands each received byte to the game logic through a valid/ack handshake.

## Interface
- CLKS_PER_BIT, default 5208: CLOCK_50 cycles per serial bit; must be ≥ 4. Benches use 8.
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- S_data_in  input  1  serial line from the remote transmitter, asynchronous to CLOCK_50, idle high.
- rx_ack  input  1  consumer accepts P_data_out; only meaningful while rx_valid=1.
- P_data_out  output  8  last received byte.
- rx_valid  output  1  P_data_out holds an unconsumed byte.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- overrun  output  1  sticky: a completed byte was dropped because rx_valid was still set.
- busy  output  1  high in every state except IDLE.

## Operation
- **Synchronizer:** S_data_in passes through two flops, both reset to 1. Call the output rx_s. All logic uses rx_s only.
- **Counters:**
  - Bit-period counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
  - Bit index is 3 bits.
  - Shift register is 8 bits and shifts left: {sh[6:0], rx_s}. The first data bit therefore lands in bit 7.
- **States:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** when rx_s=0, go to START and clear the counter.
- **START:** at count CLKS_PER_BIT/2-1 (the mid-bit point), sample rx_s.
  - 0: go to DATA, clear the counter and bit index.
  - 1: glitch; return to IDLE with no outputs changed.
- **DATA:** at count CLKS_PER_BIT-1, shift rx_s in and clear the counter.
  - After the 8th sample (index 7), go to STOP.
  - Otherwise increment the index.
- **STOP:** at count CLKS_PER_BIT-1, sample rx_s.
  - 1: byte complete; apply the handshake rules below, then go to IDLE.
  - 0: pulse frame_err, discard the byte, go to BREAK.
- **BREAK:** stay until rx_s=1, then go to IDLE. No new frame can start until the line returns high.
- **Handshake, byte complete:**
  - rx_valid=0: load P_data_out and set rx_valid.
  - rx_valid=1 and rx_ack=1 in the same cycle: load the new byte and keep rx_valid=1. No overrun.
  - rx_valid=1 and rx_ack=0: keep the old byte and set overrun.
- **Handshake, ack only:** rx_ack=1 while rx_valid=1 with no completion clears rx_valid. It also clears overrun.
- **Ignored ack:** rx_ack while rx_valid=0 has no effect.
- **Reset mid-frame:** asserting reset at any time aborts the frame immediately. After release, the receiver waits in IDLE for a fresh falling edge. A partially seen frame is never completed.

## Timing
- **Reset values:** P_data_out=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0. FSM=IDLE; counters=0; synchronizer flops=1.
- **Pin to rx_s:** 2 cycles.
- **Cycle reference:** let t0 be the first cycle in which rx_s=0 is seen in IDLE.
  - START is entered at t0+1, so busy=1 from t0+1.
  - Start-bit sample at t0+CLKS_PER_BIT/2.
  - Data bit i (i=0..7) sampled at t0+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at t0+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- **Completion:** rx_valid (or frame_err) rises on the cycle after the stop sample. On that same cycle the FSM is IDLE (or BREAK) and busy=0 (or 1).
- **Back-to-back frames:** a frame may start on the first cycle after returning to IDLE. Back-to-back frames from the transmitter are received with no gap.
- **Output behaviour:** rx_valid remains high indefinitely until acked. P_data_out is stable while rx_valid=1.

## Test plan
All scenarios use CLKS_PER_BIT=8.
1. **Reset:** hold reset=0 with random S_data_in → all outputs at reset values and busy=0. Release, idle line → nothing changes.
2. **Single byte:** send 8'hA5 (line 0,1,0,1,0,0,1,0,1,1) → rx_valid=1 and P_data_out=8'hA5 exactly one cycle after the stop sample. Ack → rx_valid=0 next cycle.
3. **Glitch and framing error:**
   - 3-cycle low pulse on the line → returns to IDLE, no rx_valid, no frame_err.
   - Frame 8'h3C with stop bit 0 → one-cycle frame_err and rx_valid stays 0. The receiver stays BREAK/busy until the line goes high, then receives 8'h01 correctly.
4. **Overrun:** send 8'h11 and 8'h22 back-to-back without ack → P_data_out=8'h11 and overrun=1. Ack → rx_valid=0 and overrun=0.
5. **Simultaneous ack/complete:** assert rx_ack for 8'h11 on exactly the cycle 8'h22 completes → P_data_out=8'h22, rx_valid=1, overrun=0.
6. **Reset mid-frame:** pulse reset low during data bit 4 of 8'hFF → outputs reset and FSM=IDLE. The remainder of that frame (all bits 1, ending with the stop bit) produces no rx_valid. The next frame 8'h5A is received correctly.

Source files
------------

// File: rtl/s2p_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : s2p_rx_if
// Brief    : Serial line plus byte valid/ack handshake of the battle-link receiver
// Revision : 1.0 - initial release
// ============================================================================
interface s2p_rx_if;
    logic       S_data_in;
    logic       rx_ack;
    logic [7:0] P_data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // master: the receiver; slave: the line driver / byte consumer
    modport master (
        input  S_data_in,
        input  rx_ack,
        output P_data_out,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output S_data_in,
        output rx_ack,
        input  P_data_out,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/s2p_rx.sv
`default_nettype none
// ============================================================================
// Module   : s2p_rx
// Brief    : 10-bit frame (start 0, 8 data MSB first, stop 1) serial-to-parallel
//            receiver with valid/ack byte handoff
// Revision : 1.0 - initial release
// ============================================================================
module s2p_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  wire logic    CLOCK_50,
    input  wire logic    reset,
    s2p_rx_if.master     bus
);

    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_mid  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    logic          w_rx_s;
    logic          w_done;
    logic          w_ack;

    assign w_rx_s = sync2_q;
    assign w_ack  = bus.rx_ack & valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        w_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!w_rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == c_mid) begin
                    cnt_d = '0;
                    if (!w_rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == c_last) begin
                    cnt_d = '0;
                    sh_d  = {sh_q[6:0], w_rx_s};
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == c_last) begin
                    cnt_d = '0;
                    if (w_rx_s) begin
                        w_done  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (w_rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // An ack landing on the completion cycle frees the slot for the new byte
        if (w_done) begin
            if (!valid_q || bus.rx_ack) begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (w_ack) begin
            valid_d = 1'b0;
        end
        if (w_ack) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= bus.S_data_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.P_data_out = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_s2p_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2p_rx
// Brief    : Self-checking bench for s2p_rx with a timestamp-based frame model
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2p_rx;
    localparam int CPB = 8;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    logic pin      = 1'b1;
    logic ack_force = 1'b0;
    logic rand_en   = 1'b0;
    logic rand_bit  = 1'b0;

    s2p_rx_if bus();
    assign bus.S_data_in = pin;
    assign bus.rx_ack    = ack_force | (rand_en & rand_bit);

    s2p_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int rise_cnt = 0;
    int ferr_cnt = 0;
    logic prev_valid = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;
    always @(posedge CLOCK_50) begin
        #1;
        rand_bit = ($urandom_range(0, 3) == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sample instants are fixed offsets from the first low rx_s cycle
    logic       m_s1 = 1'b1, m_s2 = 1'b1;
    int         m_n = 0, m_t0 = 0, m_mode = 0;  // 0 idle, 1 in frame, 2 line break
    logic [7:0] m_sh = 8'h00, m_data = 8'h00;
    logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;

    always @(posedge CLOCK_50) begin : model
        int   rel;
        logic rs, done, ack;
        if (!reset) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_sh = 8'h00;
            m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
        end else begin
            rs   = m_s2;
            ack  = bus.rx_ack;
            done = 1'b0;
            m_ferr = 1'b0;
            rel = m_n - m_t0;
            if (m_mode == 0) begin
                if (!rs) begin m_mode = 1; m_t0 = m_n; end
            end else if (m_mode == 1) begin
                if (rel == CPB / 2 && rs) m_mode = 0;
                else if (rel > CPB / 2 && rel <= CPB / 2 + 8 * CPB && (rel % CPB) == (CPB / 2) % CPB)
                    m_sh = {m_sh[6:0], rs};
                else if (rel == CPB / 2 + 9 * CPB) begin
                    if (rs) begin done = 1'b1; m_mode = 0; end
                    else begin m_ferr = 1'b1; m_mode = 2; end
                end
            end else if (rs) begin
                m_mode = 0;
            end
            if (done) begin
                if (!m_valid || ack) begin m_data = m_sh; m_valid = 1'b1; end
                else m_ovr = 1'b1;
                if (m_valid && ack) m_ovr = 1'b0;
            end else if (m_valid && ack) begin
                m_valid = 1'b0; m_ovr = 1'b0;
            end
            m_busy = (m_mode != 0);
            m_s2 = m_s1;
            m_s1 = pin;
        end
        m_n++;
    end

    always @(negedge CLOCK_50) begin
        if (reset) begin
            chk("rx_valid", {31'd0, bus.rx_valid}, {31'd0, m_valid});
            chk("P_data_out", {24'd0, bus.P_data_out}, {24'd0, m_data});
            chk("overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
            chk("frame_err", {31'd0, bus.frame_err}, {31'd0, m_ferr});
            chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        end
        if (bus.rx_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_valid = bus.rx_valid;
        if (bus.frame_err) ferr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        pin = 1'b0;
        tick(CPB);
        for (int i = 7; i >= 0; i--) begin
            pin = b[i];
            tick(CPB);
        end
        pin = stop;
        tick(CPB);
    endtask

    task automatic do_ack();
        ack_force = 1'b1;
        tick(1);
        ack_force = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
        chk({tag, " P_data_out"}, {24'd0, bus.P_data_out}, 32'h00);
        chk({tag, " overrun"}, {31'd0, bus.overrun}, 32'd0);
        chk({tag, " frame_err"}, {31'd0, bus.frame_err}, 32'd0);
        chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int f0, rc0, r;
        // 1: reset held with a noisy line
        for (int i = 0; i < 6; i++) begin
            pin = 1'($urandom_range(0, 1));
            tick(1);
            chk_reset_outputs("rst");
        end
        reset = 1'b1;
        pin   = 1'b1;
        tick(10);
        chk("idle rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("idle busy", {31'd0, bus.busy}, 32'd0);

        // 2: single byte with completion latency
        send(8'hA5, 1'b1);
        chk("A5 data", {24'd0, bus.P_data_out}, 32'hA5);
        chk("A5 valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("A5 latency", rise_cyc - start_cyc, 32'd79);
        do_ack();
        chk("A5 ack valid", {31'd0, bus.rx_valid}, 32'd0);
        tick(4);

        // 3: glitch, then framing error and break recovery
        f0 = ferr_cnt;
        pin = 1'b0;
        tick(3);
        pin = 1'b1;
        tick(12);
        chk("glitch busy", {31'd0, bus.busy}, 32'd0);
        chk("glitch valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("glitch ferr", ferr_cnt - f0, 32'd0);
        send(8'h3C, 1'b0);
        tick(10);
        chk("break busy", {31'd0, bus.busy}, 32'd1);
        chk("ferr pulses", ferr_cnt - f0, 32'd1);
        chk("ferr valid", {31'd0, bus.rx_valid}, 32'd0);
        pin = 1'b1;
        tick(4);
        chk("break exit busy", {31'd0, bus.busy}, 32'd0);
        tick(6);
        send(8'h01, 1'b1);
        chk("01 data", {24'd0, bus.P_data_out}, 32'h01);
        chk("01 valid", {31'd0, bus.rx_valid}, 32'd1);
        do_ack();
        tick(4);

        // 4: overrun with back-to-back frames
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        chk("ovr data", {24'd0, bus.P_data_out}, 32'h11);
        chk("ovr flag", {31'd0, bus.overrun}, 32'd1);
        chk("ovr valid", {31'd0, bus.rx_valid}, 32'd1);
        do_ack();
        chk("ovr ack valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("ovr ack flag", {31'd0, bus.overrun}, 32'd0);
        tick(4);

        // 5: ack on exactly the completion cycle of the second byte
        fork
            begin
                send(8'h11, 1'b1);
                send(8'h22, 1'b1);
            end
            begin
                tick(2 * 10 * CPB - 2);
                ack_force = 1'b1;
                tick(1);
                ack_force = 1'b0;
            end
        join
        chk("simul data", {24'd0, bus.P_data_out}, 32'h22);
        chk("simul valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("simul ovr", {31'd0, bus.overrun}, 32'd0);
        do_ack();
        tick(4);

        // 6: reset during data bit 4 of 8'hFF
        rc0 = rise_cnt;
        pin = 1'b0;
        tick(CPB);
        pin = 1'b1;
        tick(4 * CPB + 4);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick(2);
        reset = 1'b1;
        tick(10 * CPB - (5 * CPB + 6) + 10);
        chk("midrst no valid", rise_cnt - rc0, 32'd0);
        chk("midrst busy", {31'd0, bus.busy}, 32'd0);
        send(8'h5A, 1'b1);
        chk("5A data", {24'd0, bus.P_data_out}, 32'h5A);
        chk("5A valid", {31'd0, bus.rx_valid}, 32'd1);
        do_ack();
        tick(4);

        // Randomized traffic with random acks, glitches and bad stop bits
        rand_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                pin = 1'b0;
                tick(int'($urandom_range(1, 3)));
                pin = 1'b1;
                tick(CPB);
            end else begin
                send(8'($urandom_range(0, 255)), (r != 1));
                if (r == 1) begin
                    tick(int'($urandom_range(0, 5)));
                    pin = 1'b1;
                end
            end
            tick(int'($urandom_range(0, 12)));
        end
        rand_en = 1'b0;
        tick(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
